// File: rtl/func_sweep_ctrl.sv
// Exhaustive sweep controller for a 4-input combinational circuit: steps {A,B,C,D}
// through 0..15, captures F for each vector and grades it against a golden table.
module func_sweep_ctrl #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h0DD0
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  fail_count
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] cnt_q;
  logic       miss;
  logic [4:0] fail_d;

  // fail_d includes the vector being sampled now, so pass can be graded on the last edge
  always_comb begin
    miss   = f_in ^ EXPECTED[idx_q];
    fail_d = fail_count + {4'd0, miss};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      abcd       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      table_out  <= '0;
      fail_count <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q    <= WAIT;
            idx_q      <= '0;
            cnt_q      <= '0;
            abcd       <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            table_out  <= '0;
            fail_count <= '0;
          end
        end
        WAIT: begin
          if (abort) begin
            state_q <= IDLE;
            abcd    <= '0;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 4'(SETTLE - 1)) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          // abort discards the vector in flight; earlier captures are kept
          if (abort) begin
            state_q <= IDLE;
            abcd    <= '0;
            busy    <= 1'b0;
          end else begin
            table_out[idx_q] <= f_in;
            fail_count       <= fail_d;
            if (idx_q == 4'd15) begin
              state_q <= DONE;
              pass    <= (fail_d == 5'd0);
              done    <= 1'b1;
              busy    <= 1'b0;
              abcd    <= '0;
            end else begin
              state_q <= WAIT;
              idx_q   <= idx_q + 4'd1;
              abcd    <= idx_q + 4'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: golden, stuck-at, abort, async reset and
// held-start sweeps against hand-computed expectations.
module tb_func_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start, abort;
  logic [1:0]  mode;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy, done, pass;
  logic [15:0] table_out;
  logic [4:0]  fail_count;

  logic        start3, abort3, f_in3;
  logic [3:0]  abcd3;
  logic        busy3, done3, pass3;
  logic [15:0] table3;
  logic [4:0]  fail3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic fmodel(input logic [3:0] v);
    return (v[3] ^ v[2]) & (v[1] | ~v[0]);
  endfunction

  // mode 0: golden circuit, 1: stuck at 0, 2: stuck at 1
  assign f_in  = (mode == 2'd0) ? fmodel(abcd) : (mode == 2'd2);
  assign f_in3 = fmodel(abcd3);

  func_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'h0DD0)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .f_in(f_in),
    .abcd(abcd), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out), .fail_count(fail_count));

  func_sweep_ctrl #(.SETTLE(3), .EXPECTED(16'h0DD0)) dut3 (
    .clk(clk), .reset_b(reset_b), .start(start3), .abort(abort3), .f_in(f_in3),
    .abcd(abcd3), .busy(busy3), .done(done3), .pass(pass3),
    .table_out(table3), .fail_count(fail3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, then 32 edges; vector k/2 is on abcd after edge k
  task automatic run_sweep(input logic [15:0] exp_tbl, input logic [4:0] exp_fail,
                           input logic exp_pass);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_abcd", 32'(abcd), 32'd0);
    for (int k = 1; k < 32; k++) begin
      tick();
      chk("sweep_abcd", 32'(abcd), 32'(k / 2));
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_done", 32'(done), 32'd0);
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd0);
    chk("done_abcd",  32'(abcd), 32'd0);
    chk("table",      32'(table_out), 32'(exp_tbl));
    chk("fail_count", 32'(fail_count), 32'(exp_fail));
    chk("pass",       32'(pass), 32'(exp_pass));
    tick();
    chk("done_1cyc",  32'(done), 32'd0);
    chk("hold_table", 32'(table_out), 32'(exp_tbl));
    chk("hold_pass",  32'(pass), 32'(exp_pass));
  endtask

  initial begin
    reset_b = 1'b0;
    start = 1'b0; abort = 1'b0; mode = 2'd0;
    start3 = 1'b0; abort3 = 1'b0;
    #12;
    chk("rst_abcd",  32'(abcd), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pass",  32'(pass), 32'd0);
    chk("rst_table", 32'(table_out), 32'd0);
    chk("rst_fail",  32'(fail_count), 32'd0);
    #5 reset_b = 1'b1;

    // golden sweep, start accepted on first edge after release
    run_sweep(16'h0DD0, 5'd0, 1'b1);

    mode = 2'd1;
    run_sweep(16'h0000, 5'd6, 1'b0);
    mode = 2'd2;
    run_sweep(16'hFFFF, 5'd10, 1'b0);
    mode = 2'd0;

    // abort raised after edge 10, seen at edge 11
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("pre_abort_abcd", 32'(abcd), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_abcd",  32'(abcd), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_table", 32'(table_out), 32'h0010);
    chk("abort_fail",  32'(fail_count), 32'd0);
    chk("abort_pass",  32'(pass), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle",    32'(busy), 32'd0);
    end
    run_sweep(16'h0DD0, 5'd0, 1'b1);

    // async reset between edges while in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midwait_abcd", 32'(abcd), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    chk("async_abcd",  32'(abcd), 32'd0);
    chk("async_busy",  32'(busy), 32'd0);
    chk("async_table", 32'(table_out), 32'd0);
    chk("async_fail",  32'(fail_count), 32'd0);
    chk("async_pass",  32'(pass), 32'd0);
    #1 reset_b = 1'b1;
    run_sweep(16'h0DD0, 5'd0, 1'b1);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_abcd", 32'(abcd), 32'd0);
    end
    start = 1'b0; abort = 1'b0;

    // SETTLE=3 with start held high
    start3 = 1'b1;
    tick();
    chk("s3_accept", 32'(busy3), 32'd1);
    for (int k = 1; k < 64; k++) begin
      tick();
      chk("s3_busy", 32'(busy3), 32'd1);
      chk("s3_abcd", 32'(abcd3), 32'(k / 4));
      chk("s3_done", 32'(done3), 32'd0);
    end
    tick();
    chk("s3_done64",  32'(done3), 32'd1);
    chk("s3_busy64",  32'(busy3), 32'd0);
    chk("s3_pass",    32'(pass3), 32'd1);
    chk("s3_table",   32'(table3), 32'h0DD0);
    tick();
    chk("s3_idle_busy", 32'(busy3), 32'd0);
    chk("s3_idle_done", 32'(done3), 32'd0);
    tick();
    chk("s3_restart",      32'(busy3), 32'd1);
    chk("s3_restart_abcd", 32'(abcd3), 32'd0);
    chk("s3_restart_pass", 32'(pass3), 32'd0);
    start3 = 1'b0;
    abort3 = 1'b1;
    tick();
    abort3 = 1'b0;
    chk("s3_abort", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/func_sweep_ctrl.md
FUNC_SWEEP_CTRL -- requirements
Module: func_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning clock cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 SHALL have parameter EXPECTED, default 16'h0DD0, meaning the golden truth table, where bit i is the expected F for the vector {A,B,C,D}=i.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_b, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one exhaustive sweep.
REQ-006 SHALL have port abort, input, 1 bit: cancel the sweep in progress.
REQ-007 SHALL have port f_in, input, 1 bit: response F of the 4-input function circuit under control.
REQ-008 SHALL have port abcd, output, 4 bits: drives the circuit inputs; A=abcd[3], B=abcd[2], C=abcd[1], D=abcd[0].
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port pass, output, 1 bit: high when the last completed sweep matched EXPECTED.
REQ-012 SHALL have port table_out, output, 16 bits: captured truth table; bit i is f_in sampled for vector i.
REQ-013 SHALL have port fail_count, output, 5 bits: number of mismatching vectors, range 0..16.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT, SAMPLE and DONE.
REQ-015 IDLE: start=1 and abort=0 SHALL cause the next state WAIT, with index=0, abcd=0, table_out=0, fail_count=0 and pass=0.
REQ-016 WAIT SHALL last exactly SETTLE cycles with abcd=index held stable, then move to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle, at whose closing edge it sets table_out[index]=f_in and increments fail_count (5-bit, no wrap possible) when f_in != EXPECTED[index].
REQ-018 SAMPLE with index<15 SHALL increment index, update abcd to index+1 on the same edge, and return to WAIT.
REQ-019 SAMPLE with index==15 SHALL go to DONE, with pass loaded as (final fail_count==0) on that edge.
REQ-020 DONE SHALL last one cycle with done=1 and abcd=0, then return to IDLE unconditionally.
REQ-021 Vectors SHALL be applied in ascending order 0..15, each exactly once per sweep.
REQ-022 Latency: the state SHALL be DONE immediately after the 16*(SETTLE+1)-th rising edge following the edge that accepted start (32 for SETTLE=1).
REQ-023 busy SHALL be 1 in WAIT and SAMPLE and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in WAIT, SAMPLE and DONE; start held continuously high SHALL begin a new sweep from IDLE one cycle after DONE.
REQ-025 abort=1 in WAIT or SAMPLE SHALL force IDLE on the next edge with abcd=0 and no done pulse; table_out and fail_count retain their partial values and pass stays 0.
REQ-026 abort=1 together with start=1 in IDLE SHALL keep the FSM in IDLE, with abort winning.
REQ-027 abort in DONE SHALL have no effect: the done pulse still occurs.
REQ-028 table_out, fail_count and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-029 reset_b=0 SHALL immediately, independent of clk, force state IDLE, index=0, abcd=0, busy=0, done=0, pass=0, table_out=0 and fail_count=0.
REQ-030 Release of reset_b SHALL take effect at the first rising edge with reset_b=1; start sampled at that edge SHALL be accepted.

Verification
REQ-031 SETTLE=1, f_in modelled as (A^B)&(C|~D) of abcd, start pulsed -> done at edge 32, table_out=16'h0DD0, fail_count=0, pass=1, abcd visits 0..15 in order.
REQ-032 f_in stuck 0 -> table_out=16'h0000, fail_count=6, pass=0; f_in stuck 1 -> table_out=16'hFFFF, fail_count=10, pass=0.
REQ-033 abort asserted at edge 10 of a sweep -> busy=0 and abcd=0 after edge 11, no done pulse; a following start gives a complete clean sweep.
REQ-034 reset_b pulsed low mid-WAIT between clock edges -> all outputs 0 immediately; start after release -> normal sweep.
REQ-035 SETTLE=3, start held high -> done at edge 64, busy low for exactly 2 cycles (DONE and IDLE), then a second sweep begins.
REQ-036 start and abort both high in IDLE -> busy stays 0 and abcd stays 0.
